// File: rtl/preset_ctrl_if.sv
// Handshake bundle between the preset controller and its front panel / MIDI logic.
// The master side drives the button, program and tx_ready inputs; the slave side is the controller.
interface preset_ctrl_if;
  logic [1:0] btn_index;
  logic       save_mode;
  logic       prog_valid;
  logic [6:0] prog_num;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       led;
  logic       busy;

  modport master (
    output btn_index, save_mode, prog_valid, prog_num, tx_ready,
    input  tx_valid, tx_data, led, busy
  );

  modport slave (
    input  btn_index, save_mode, prog_valid, prog_num, tx_ready,
    output tx_valid, tx_data, led, busy
  );
endinterface

// File: rtl/preset_ctrl.sv
// Two-slot MIDI program preset store: saves the last received Program Change
// and replays it as a two-byte Program Change message on recall.
module preset_ctrl #(
  parameter logic [3:0] MIDI_CH   = 4'd0,
  parameter int         BLINK_CNT = 21
) (
  input  logic         clk,
  input  logic         rst,
  preset_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, TX_STATUS, TX_PROG, BLINK} state_e;

  localparam logic [BLINK_CNT-1:0] CNT_ONE = BLINK_CNT'(1);

  state_e               state_q, state_d;
  logic [BLINK_CNT-1:0] cnt_q, cnt_d;
  logic [6:0]           last_prog_q, last_prog_d;
  logic                 have_prog_q, have_prog_d;
  logic [1:0][6:0]      slot_q, slot_d;
  logic [1:0]           full_q, full_d;
  logic [6:0]           tx_prog_q, tx_prog_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 led_q, led_d;
  logic                 busy_q, busy_d;

  logic btn_hit;
  logic sel;

  // btn_index 1 -> slot 0, 2 -> slot 1; 0 and 3 never qualify
  assign btn_hit = (bus.btn_index == 2'd1) || (bus.btn_index == 2'd2);
  assign sel     = bus.btn_index[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_prog_d = last_prog_q;
    have_prog_d = have_prog_q;
    slot_d      = slot_q;
    full_d      = full_q;
    tx_prog_d   = tx_prog_q;

    // Saves below read last_prog_q, so a same-cycle program update lands after the save
    if (bus.prog_valid) begin
      last_prog_d = bus.prog_num;
      have_prog_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (btn_hit && bus.save_mode && have_prog_q) begin
          slot_d[sel] = last_prog_q;
          full_d[sel] = 1'b1;
          cnt_d       = '1;
          state_d     = BLINK;
        end else if (btn_hit && !bus.save_mode && full_q[sel]) begin
          tx_prog_d = slot_q[sel];
          state_d   = TX_STATUS;
        end
      end
      TX_STATUS: if (tx_valid_q && bus.tx_ready) state_d = TX_PROG;
      TX_PROG:   if (tx_valid_q && bus.tx_ready) state_d = IDLE;
      BLINK: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it
    tx_valid_d = (state_d == TX_STATUS) || (state_d == TX_PROG);
    tx_data_d  = 8'h00;
    if (state_d == TX_STATUS)    tx_data_d = {4'hC, MIDI_CH};
    else if (state_d == TX_PROG) tx_data_d = {1'b0, tx_prog_d};
    led_d  = (state_d == BLINK);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_prog_q <= '0;
      have_prog_q <= 1'b0;
      slot_q      <= '0;
      full_q      <= '0;
      tx_prog_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_prog_q <= last_prog_d;
      have_prog_q <= have_prog_d;
      slot_q      <= slot_d;
      full_q      <= full_d;
      tx_prog_q   <= tx_prog_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.led      = led_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_preset_ctrl.sv
// Directed plus random stimulus for preset_ctrl, scored against a transaction-level
// model: an outgoing byte queue, a blink countdown and plain slot arrays.
module tb_preset_ctrl;
  localparam int         BLINK_CNT = 4;
  localparam int         BLINK_LEN = 1 << BLINK_CNT;
  localparam logic [3:0] MIDI_CH   = 4'd0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  preset_ctrl_if bus ();

  preset_ctrl #(.MIDI_CH(MIDI_CH), .BLINK_CNT(BLINK_CNT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // reference model
  logic [6:0] m_slot [2];
  bit         m_full [2];
  logic [6:0] m_last;
  bit         m_have;
  logic [7:0] m_txq [$];
  int         m_blink;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_slot[0] = '0; m_slot[1] = '0;
    m_full[0] = 0;  m_full[1] = 0;
    m_last = '0; m_have = 0;
    m_txq.delete();
    m_blink = 0;
  endtask

  task automatic check_outputs(input string tag);
    bit         busy_e;
    logic [7:0] data_e;
    busy_e = (m_txq.size() != 0) || (m_blink > 0);
    data_e = (m_txq.size() != 0) ? m_txq[0] : 8'h00;
    chk({tag, ".tx_valid"}, {7'd0, bus.tx_valid}, {7'd0, m_txq.size() != 0});
    chk({tag, ".tx_data"},  bus.tx_data, data_e);
    chk({tag, ".led"},      {7'd0, bus.led}, {7'd0, m_blink > 0});
    chk({tag, ".busy"},     {7'd0, bus.busy}, {7'd0, busy_e});
  endtask

  // One clock: apply inputs, advance model at the edge, check just after.
  task automatic step(input logic [1:0] bi, input logic sm, input logic pv,
                      input logic [6:0] pn, input logic rdy, input string tag);
    int s;
    bus.btn_index  = bi;
    bus.save_mode  = sm;
    bus.prog_valid = pv;
    bus.prog_num   = pn;
    bus.tx_ready   = rdy;
    @(posedge clk);
    if (m_txq.size() != 0) begin
      if (rdy) void'(m_txq.pop_front());
    end else if (m_blink > 0) begin
      m_blink--;
    end else if (bi == 2'd1 || bi == 2'd2) begin
      s = (bi == 2'd2) ? 1 : 0;
      if (sm && m_have) begin
        m_slot[s] = m_last;
        m_full[s] = 1;
        m_blink   = BLINK_LEN;
      end else if (!sm && m_full[s]) begin
        m_txq.push_back({4'hC, MIDI_CH});
        m_txq.push_back({1'b0, m_slot[s]});
      end
    end
    if (pv) begin
      m_last = pn;
      m_have = 1;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input logic rdy, input string tag);
    for (int i = 0; i < n; i++) step(2'd0, 1'b0, 1'b0, 7'd0, rdy, tag);
  endtask

  // Asserts reset a few ns after an edge, checks the async clear, releases on a negedge.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    model_clear();
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.btn_index = '0; bus.save_mode = 0; bus.prog_valid = 0;
    bus.prog_num = '0; bus.tx_ready = 0;
    model_clear();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // empty slot recall, invalid index, save with nothing to store
    step(2'd2, 1'b0, 1'b0, 7'd0, 1'b1, "recall_empty");
    idle(2, 1'b1, "recall_empty_after");
    step(2'd3, 1'b1, 1'b0, 7'd0, 1'b1, "btn3");
    step(2'd1, 1'b1, 1'b0, 7'd0, 1'b1, "save_no_prog");
    idle(1, 1'b1, "save_no_prog_after");
    step(2'd1, 1'b0, 1'b0, 7'd0, 1'b1, "recall_unsaved");
    idle(1, 1'b1, "recall_unsaved_after");

    // store 0x2A into slot0, blink, then recall with full-rate tx_ready
    step(2'd0, 1'b0, 1'b1, 7'h2A, 1'b1, "prog_2a");
    step(2'd1, 1'b1, 1'b0, 7'd0, 1'b1, "save_slot0");
    idle(BLINK_LEN + 1, 1'b1, "blink");
    step(2'd1, 1'b0, 1'b0, 7'd0, 1'b1, "recall_slot0");
    idle(3, 1'b1, "recall_slot0_tx");

    // backpressure: tx_ready low for 5 cycles
    step(2'd1, 1'b0, 1'b0, 7'd0, 1'b0, "recall_stall");
    idle(5, 1'b0, "stall_hold");
    idle(3, 1'b1, "stall_release");

    // btn during TX_PROG is dropped
    step(2'd1, 1'b0, 1'b0, 7'd0, 1'b1, "recall_drop");
    step(2'd0, 1'b0, 1'b0, 7'd0, 1'b0, "tx_prog_hold");
    step(2'd2, 1'b0, 1'b0, 7'd0, 1'b1, "btn_in_tx_prog");
    idle(3, 1'b1, "drop_after");

    // prog change during BLINK, plus simultaneous save+prog
    step(2'd2, 1'b1, 1'b0, 7'd0, 1'b1, "save_slot1");
    step(2'd0, 1'b0, 1'b1, 7'h05, 1'b1, "prog_in_blink");
    idle(BLINK_LEN, 1'b1, "blink2");
    step(2'd2, 1'b1, 1'b1, 7'h7F, 1'b1, "save_with_prog");
    idle(BLINK_LEN + 1, 1'b1, "blink3");
    step(2'd2, 1'b0, 1'b0, 7'd0, 1'b1, "recall_slot1");
    idle(3, 1'b1, "recall_slot1_tx");

    // reset mid TX_STATUS clears the slot
    step(2'd1, 1'b0, 1'b0, 7'd0, 1'b0, "recall_before_rst");
    pulse_reset("rst_mid_tx");
    step(2'd1, 1'b0, 1'b0, 7'd0, 1'b1, "recall_after_rst");
    idle(3, 1'b1, "recall_after_rst_idle");

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [1:0] bi;
      bi = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      step(bi, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
           7'($urandom_range(0, 127)), ($urandom_range(0, 2) != 0), "rand");
      if (i == 300) pulse_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/preset_ctrl.md
PRESET_CTRL -- requirements
Module: preset_ctrl

Interface
REQ-001 Parameter MIDI_CH, default 0, 4-bit MIDI channel placed in the Program Change status byte.
REQ-002 Parameter BLINK_CNT, default 21, width of the LED blink counter; blink lasts 2^BLINK_CNT clk cycles.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 btn_index  input  2  one-cycle button event: 1 = slot 0, 2 = slot 1, 0 = none, 3 = invalid.
REQ-006 save_mode  input  1  qualifies btn_index in the same cycle: 1 = store, 0 = recall.
REQ-007 prog_valid  input  1  one-cycle strobe: a Program Change was received on MIDI in.
REQ-008 prog_num  input  7  received program number; sampled only when prog_valid=1.
REQ-009 tx_ready  input  1  MIDI transmitter can accept a byte.
REQ-010 tx_valid  output  1  tx_data holds a byte to send.
REQ-011 tx_data  output  8  byte to send.
REQ-012 led  output  1  save-confirm indicator.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 Internal state SHALL be: last_prog (7b) with have_prog flag; slot0/slot1 (7b each), each with a full flag.
REQ-015 prog_valid=1 SHALL load last_prog<=prog_num and set have_prog in every state, including when busy.
REQ-016 FSM states SHALL be IDLE, TX_STATUS, TX_PROG and BLINK.
REQ-017 IDLE, btn_index in {1,2}, save_mode=1, have_prog=1: write last_prog into the selected slot, set its full flag, reload the blink counter, go to BLINK next cycle.
REQ-018 IDLE, save with have_prog=0: no slot change, stay in IDLE.
REQ-019 IDLE, btn_index in {1,2}, save_mode=0, selected slot full: latch the slot value into tx_prog, go to TX_STATUS.
REQ-020 IDLE, recall of an empty slot: no transmit, stay in IDLE.
REQ-021 btn_index=3, or btn_index=0, SHALL be ignored.
REQ-022 Any btn_index event while busy=1 SHALL be dropped; events are not queued.
REQ-023 A simultaneous prog_valid and save in IDLE SHALL store the old last_prog; the new value applies from the next cycle.
REQ-024 TX_STATUS SHALL drive tx_valid=1 and tx_data={4'hC, MIDI_CH}; on tx_valid&tx_ready, go to TX_PROG.
REQ-025 TX_PROG SHALL drive tx_valid=1 and tx_data={1'b0, tx_prog}; on tx_valid&tx_ready, go to IDLE.
REQ-026 While tx_ready=0, tx_valid and tx_data SHALL stay constant; outside TX states tx_valid=0 and tx_data=0.
REQ-027 tx_data and tx_valid SHALL come directly from registered state, with no combinational path from tx_ready.
REQ-028 BLINK SHALL hold led=1 and decrement the counter from 2^BLINK_CNT-1; at count 0, set led=0 and go to IDLE.
REQ-029 Minimum recall time SHALL be 2 cycles from entering TX_STATUS to IDLE, when tx_ready is held at 1.

Reset
REQ-030 rst=0 SHALL asynchronously force state=IDLE, tx_valid=0, tx_data=0, led=0, busy=0, counter=0, last_prog=0, have_prog=0, slots=0 and full flags=0.
REQ-031 After rst rises, the first event SHALL be accepted on the first clk edge.
REQ-032 Reset mid-transmit or mid-blink SHALL abort the operation; it is not resumed.

Verification
REQ-033 prog_valid with prog_num=0x2A, then btn_index=1 with save_mode=1 -> led=1 for 2^BLINK_CNT cycles, slot0 full; later btn_index=1 with save_mode=0 -> bytes 0xC0 then 0x2A.
REQ-034 Recall while tx_ready is held 0 for 5 cycles -> tx_valid=1 and tx_data=0xC0 stable throughout; no byte skipped after tx_ready rises.
REQ-035 Recall of empty slot1 after reset -> tx_valid stays 0 and busy stays 0.
REQ-036 btn_index=2 arriving during TX_PROG -> dropped, no second transmission; btn_index=3 in IDLE -> no effect.
REQ-037 Save with have_prog=0 -> no blink, slot stays empty; prog_valid=0x05 arriving during BLINK -> a later save stores 0x05.
REQ-038 rst pulsed low during TX_STATUS -> tx_valid=0 immediately; a recall of the same slot after reset sends nothing (slot cleared).
